// File: rtl/controlador_carga_hd_pkg.sv
// Shared definitions for the program-load controller.
// Holds the FSM state encoding and the default address width and HD read
// latency used by controlador_carga_hd.
package controlador_carga_hd_pkg;

    localparam int LARGURA_END_PADRAO = 10;
    localparam int LATENCIA_HD_PADRAO = 2;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        ENDERECA = 3'd1,
        ESCREVE  = 3'd2,
        EXECUTA  = 3'd3,
        PARADO   = 3'd4
    } estado_t;

endpackage

// File: rtl/controlador_carga_hd_temporizador.sv
// temporizador_hd: 4-bit load/decrement counter with a terminal flag.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   carrega     - loads valor (has priority over decrementa)
//   decrementa  - counts down by one, saturating at zero
//   valor       - value loaded on carrega
//   terminal    - high while the count is zero
module temporizador_hd (
    input  logic       clk,
    input  logic       reset,
    input  logic       carrega,
    input  logic       decrementa,
    input  logic [3:0] valor,
    output logic       terminal
);

    logic [3:0] contagem;

    always_ff @(posedge clk) begin
        if (reset) begin
            contagem <= 4'd0;
        end else if (carrega) begin
            contagem <= valor;
        end else if (decrementa && (contagem != 4'd0)) begin
            contagem <= contagem - 4'd1;
        end
    end

    assign terminal = (contagem == 4'd0);

endmodule

// File: rtl/controlador_carga_hd.sv
// controlador_carga_hd: copies a program from the HD into instruction memory
// and then releases the processor.
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   inicio         - start a load (honoured only in OCIOSO or PARADO)
//   end_base       - HD address of the first program word
//   num_palavras   - number of words to load, 0..2^LARGURA_END
//   HD_out         - HD read data, valid LATENCIA_HD cycles after end_hd
//   HALT           - processor halt (honoured only in EXECUTA)
//   end_hd         - HD read address (base + indice, modulo 2^32)
//   end_mem_inst   - instruction-memory write address
//   dado_mem_inst  - instruction-memory write data
//   esc_mem_inst   - instruction-memory write enable
//   reset_proc     - holds the processor in reset; the processor's reset
//                    input is to be driven by (reset | reset_proc)
//   ocupado        - load in progress
//   concluido      - one-cycle pulse on the first EXECUTA cycle
//   estado         - current FSM state (debug)
//
// Handshake: there is no valid/ready pair; a load is accepted on any clock
// edge where the FSM is in OCIOSO/PARADO and inicio is high. The HD is a
// fixed-latency read port: end_hd is held for LATENCIA_HD cycles in ENDERECA
// and HD_out is captured during the single ESCREVE cycle.
module controlador_carga_hd
    import controlador_carga_hd_pkg::*;
#(
    parameter int LARGURA_END = LARGURA_END_PADRAO,
    parameter int LATENCIA_HD = LATENCIA_HD_PADRAO
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inicio,
    input  logic [31:0]            end_base,
    input  logic [LARGURA_END:0]   num_palavras,
    input  logic [31:0]            HD_out,
    input  logic                   HALT,
    output logic [31:0]            end_hd,
    output logic [LARGURA_END-1:0] end_mem_inst,
    output logic [31:0]            dado_mem_inst,
    output logic                   esc_mem_inst,
    output logic                   reset_proc,
    output logic                   ocupado,
    output logic                   concluido,
    output logic [2:0]             estado
);

    // The timer counts LATENCIA_HD-1 down to 0, so ENDERECA lasts exactly
    // LATENCIA_HD cycles including the cycle the count reaches zero.
    localparam logic [3:0]           CARGA_LAT = 4'(LATENCIA_HD - 1);
    localparam logic [LARGURA_END:0] UM        = (LARGURA_END + 1)'(1);

    estado_t                estado_q;
    estado_t                prox;
    logic [31:0]            base_q;
    logic [LARGURA_END:0]   num_q;
    logic [LARGURA_END-1:0] indice;
    logic                   primeiro_q;
    logic                   aceita;
    logic                   ultimo;
    logic                   recarrega;
    logic                   terminal;

    assign aceita = ((estado_q == OCIOSO) || (estado_q == PARADO)) &&
                    inicio && (num_palavras != '0);

    // indice is one bit narrower than num_q, so N = 2^LARGURA_END ends at
    // indice = all ones without ever wrapping.
    assign ultimo = ({1'b0, indice} == (num_q - UM));

    assign recarrega = aceita || ((estado_q == ESCREVE) && !ultimo);

    temporizador_hd u_temporizador (
        .clk        (clk),
        .reset      (reset),
        .carrega    (recarrega),
        .decrementa (estado_q == ENDERECA),
        .valor      (CARGA_LAT),
        .terminal   (terminal)
    );

    always_comb begin
        prox = estado_q;
        case (estado_q)
            OCIOSO, PARADO: begin
                if (inicio) begin
                    prox = (num_palavras == '0) ? EXECUTA : ENDERECA;
                end
            end
            ENDERECA: begin
                if (terminal) begin
                    prox = ESCREVE;
                end
            end
            ESCREVE: begin
                prox = ultimo ? EXECUTA : ENDERECA;
            end
            EXECUTA: begin
                if (HALT) begin
                    prox = PARADO;
                end
            end
            default: begin
                prox = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            base_q     <= 32'd0;
            num_q      <= '0;
            indice     <= '0;
            primeiro_q <= 1'b0;
        end else begin
            estado_q   <= prox;
            // Registered so concluido marks only the entry cycle into EXECUTA.
            primeiro_q <= (prox == EXECUTA) && (estado_q != EXECUTA);
            if (aceita) begin
                base_q <= end_base;
                num_q  <= num_palavras;
                indice <= '0;
            end else if ((estado_q == ESCREVE) && !ultimo) begin
                indice <= indice + 1'b1;
            end
        end
    end

    assign end_hd        = base_q + 32'(indice);
    assign end_mem_inst  = indice;
    assign esc_mem_inst  = (estado_q == ESCREVE);
    assign dado_mem_inst = (estado_q == ESCREVE) ? HD_out : 32'd0;
    assign ocupado       = (estado_q == ENDERECA) || (estado_q == ESCREVE);
    assign reset_proc    = (estado_q != EXECUTA);
    assign concluido     = primeiro_q;
    assign estado        = estado_q;

endmodule

// File: tb/tb_controlador_carga_hd.sv
module tb_controlador_carga_hd;
    import controlador_carga_hd_pkg::*;

    localparam int LE  = 4;
    localparam int LAT = 2;

    // ---------------- clock / reset / DUT ----------------
    logic           clk = 1'b0;
    logic           reset;
    logic           inicio;
    logic [31:0]    end_base;
    logic [LE:0]    num_palavras;
    logic [31:0]    HD_out;
    logic           HALT;
    logic [31:0]    end_hd;
    logic [LE-1:0]  end_mem_inst;
    logic [31:0]    dado_mem_inst;
    logic           esc_mem_inst;
    logic           reset_proc;
    logic           ocupado;
    logic           concluido;
    logic [2:0]     estado;

    always #5 clk = ~clk;

    controlador_carga_hd #(.LARGURA_END(LE), .LATENCIA_HD(LAT)) dut (
        .clk           (clk),
        .reset         (reset),
        .inicio        (inicio),
        .end_base      (end_base),
        .num_palavras  (num_palavras),
        .HD_out        (HD_out),
        .HALT          (HALT),
        .end_hd        (end_hd),
        .end_mem_inst  (end_mem_inst),
        .dado_mem_inst (dado_mem_inst),
        .esc_mem_inst  (esc_mem_inst),
        .reset_proc    (reset_proc),
        .ocupado       (ocupado),
        .concluido     (concluido),
        .estado        (estado)
    );

    function automatic logic [31:0] hd_word(input logic [31:0] a);
        return a ^ 32'h0000A5A5;
    endfunction

    // HD model: word for an address appears LAT cycles after the address.
    logic [31:0] hd_pipe [LAT];
    always @(posedge clk) begin
        hd_pipe[0] <= end_hd;
        for (int i = 1; i < LAT; i++) hd_pipe[i] <= hd_pipe[i-1];
    end
    assign HD_out = hd_word(hd_pipe[LAT-1]);

    // ---------------- scoreboard ----------------
    logic [LE+31:0] exp_q[$];
    logic [LE+31:0] esperado;
    int total    = 0;
    int bad      = 0;
    int n_writes = 0;
    bit seen_ff  = 0;
    bit seen_wrap = 0;

    always @(negedge clk) begin
        if (esc_mem_inst === 1'b1) begin
            n_writes++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected: got addr=%0d data=%h, required no write",
                         end_mem_inst, dado_mem_inst);
            end else begin
                esperado = exp_q.pop_front();
                if ({end_mem_inst, dado_mem_inst} !== esperado) begin
                    bad++;
                    $display("FAIL write_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             end_mem_inst, dado_mem_inst, esperado[LE+31:32], esperado[31:0]);
                end
            end
        end
        if (end_hd == 32'hFFFF_FFFF) seen_ff = 1;
        if (seen_ff && ocupado && end_hd == 32'h0) seen_wrap = 1;
    end

    // ---------------- driver / check tasks ----------------
    task automatic verifica(input string nome, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h required=%h", nome, got, exp);
        end
    endtask

    task automatic espera_executa(input int limite, input bit alterna, input string nome);
        int n = 0;
        while (estado !== 3'(EXECUTA) && n < limite) begin
            if (alterna) inicio = ~inicio;
            @(negedge clk);
            n++;
        end
        verifica({nome, "_reach_executa"}, 32'(estado), 32'(EXECUTA));
    endtask

    task automatic carrega(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({LE'(i), hd_word(base + 32'(i))});
        inicio       = 1'b1;
        end_base     = base;
        num_palavras = (LE+1)'(n);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        inicio;
        logic        halt;
        logic [31:0] base;
        logic [LE:0] num;
        logic [2:0]  e_estado;
        logic        e_esc;
        logic        e_ocup;
        logic        e_conc;
        logic        e_rproc;
        logic [31:0] e_end_hd;
    } vetor_t;

    vetor_t tab [14];

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1);
    end

    initial begin
        int w0;
        // Main load: base 0x100, N=3, writes on cycles 3,6,9, concluido at 10.
        // Inputs in row i are driven after row i's outputs are checked.
        tab[0]  = '{1'b1, 1'b0, 32'h100,  5'd3, OCIOSO,   1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        tab[1]  = '{1'b0, 1'b0, 32'h7777, 5'd9, ENDERECA, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100};
        tab[2]  = '{1'b1, 1'b0, 32'h7777, 5'd9, ENDERECA, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100};
        tab[3]  = '{1'b0, 1'b0, 32'h7777, 5'd9, ESCREVE,  1'b1, 1'b1, 1'b0, 1'b1, 32'h100};
        tab[4]  = '{1'b0, 1'b0, 32'h7777, 5'd9, ENDERECA, 1'b0, 1'b1, 1'b0, 1'b1, 32'h101};
        tab[5]  = '{1'b0, 1'b0, 32'h7777, 5'd9, ENDERECA, 1'b0, 1'b1, 1'b0, 1'b1, 32'h101};
        tab[6]  = '{1'b0, 1'b0, 32'h7777, 5'd9, ESCREVE,  1'b1, 1'b1, 1'b0, 1'b1, 32'h101};
        tab[7]  = '{1'b0, 1'b0, 32'h7777, 5'd9, ENDERECA, 1'b0, 1'b1, 1'b0, 1'b1, 32'h102};
        tab[8]  = '{1'b0, 1'b0, 32'h7777, 5'd9, ENDERECA, 1'b0, 1'b1, 1'b0, 1'b1, 32'h102};
        tab[9]  = '{1'b0, 1'b0, 32'h7777, 5'd9, ESCREVE,  1'b1, 1'b1, 1'b0, 1'b1, 32'h102};
        tab[10] = '{1'b0, 1'b0, 32'h7777, 5'd9, EXECUTA,  1'b0, 1'b0, 1'b1, 1'b0, 32'h102};
        tab[11] = '{1'b1, 1'b1, 32'h7777, 5'd9, EXECUTA,  1'b0, 1'b0, 1'b0, 1'b0, 32'h102};
        tab[12] = '{1'b0, 1'b1, 32'h7777, 5'd9, PARADO,   1'b0, 1'b0, 1'b0, 1'b1, 32'h102};
        tab[13] = '{1'b0, 1'b0, 32'h7777, 5'd9, PARADO,   1'b0, 1'b0, 1'b0, 1'b1, 32'h102};

        reset = 1'b1; inicio = 1'b0; HALT = 1'b0; end_base = 32'h0; num_palavras = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        exp_q.push_back({4'd0, 32'h0000A4A5});
        exp_q.push_back({4'd1, 32'h0000A4A4});
        exp_q.push_back({4'd2, 32'h0000A4A7});
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            verifica($sformatf("v%0d_estado", i),  32'(estado),       32'(tab[i].e_estado));
            verifica($sformatf("v%0d_esc", i),     32'(esc_mem_inst), 32'(tab[i].e_esc));
            verifica($sformatf("v%0d_ocupado", i), 32'(ocupado),      32'(tab[i].e_ocup));
            verifica($sformatf("v%0d_concl", i),   32'(concluido),    32'(tab[i].e_conc));
            verifica($sformatf("v%0d_rproc", i),   32'(reset_proc),   32'(tab[i].e_rproc));
            verifica($sformatf("v%0d_end_hd", i),  end_hd,            tab[i].e_end_hd);
            inicio = tab[i].inicio; HALT = tab[i].halt;
            end_base = tab[i].base; num_palavras = tab[i].num;
        end
        verifica("main_pending", 32'(exp_q.size()), 32'd0);

        // N=0: straight to EXECUTA with concluido and no writes.
        w0 = n_writes;
        inicio = 1'b1; num_palavras = '0;
        @(negedge clk);
        verifica("n0_estado", 32'(estado), 32'(EXECUTA));
        verifica("n0_concl",  32'(concluido), 32'd1);
        verifica("n0_ocupado", 32'(ocupado), 32'd0);
        inicio = 1'b0;
        @(negedge clk);
        verifica("n0_concl_once", 32'(concluido), 32'd0);
        verifica("n0_writes", 32'(n_writes - w0), 32'd0);
        HALT = 1'b1;
        @(negedge clk);
        verifica("halt_estado", 32'(estado), 32'(PARADO));
        verifica("halt_rproc", 32'(reset_proc), 32'd1);
        HALT = 1'b0;

        // Reset during the second ENDERECA of an N=5 load.
        w0 = n_writes;
        exp_q.push_back({4'd0, hd_word(32'h200)});
        inicio = 1'b1; end_base = 32'h200; num_palavras = 5'd5;
        @(negedge clk);
        inicio = 1'b0;
        repeat (3) @(negedge clk);
        verifica("abort_pre_estado", 32'(estado), 32'(ENDERECA));
        verifica("abort_pre_end_hd", end_hd, 32'h201);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        verifica("abort_estado", 32'(estado), 32'(OCIOSO));
        verifica("abort_rproc", 32'(reset_proc), 32'd1);
        verifica("abort_end_hd", end_hd, 32'h0);
        repeat (6) @(negedge clk);
        verifica("abort_writes", 32'(n_writes - w0), 32'd1);
        verifica("abort_still_ocioso", 32'(estado), 32'(OCIOSO));
        carrega(32'h300, 2);
        @(negedge clk);
        inicio = 1'b0;
        espera_executa(40, 1'b0, "restart");
        verifica("restart_pending", 32'(exp_q.size()), 32'd0);

        // inicio toggled every cycle during an N=4 load.
        HALT = 1'b1;
        @(negedge clk);
        HALT = 1'b0;
        w0 = n_writes;
        carrega(32'h40, 4);
        @(negedge clk);
        espera_executa(40, 1'b1, "toggle");
        inicio = 1'b0;
        verifica("toggle_concl", 32'(concluido), 32'd1);
        verifica("toggle_writes", 32'(n_writes - w0), 32'd4);

        // HALT then reload with N=2.
        HALT = 1'b1;
        @(negedge clk);
        HALT = 1'b0;
        verifica("halt2_estado", 32'(estado), 32'(PARADO));
        verifica("halt2_rproc", 32'(reset_proc), 32'd1);
        carrega(32'h55, 2);
        @(negedge clk);
        inicio = 1'b0;
        espera_executa(40, 1'b0, "reload");
        verifica("reload_concl", 32'(concluido), 32'd1);
        verifica("reload_rproc", 32'(reset_proc), 32'd0);

        // Full memory, end_hd wraps past 0xFFFFFFFF.
        HALT = 1'b1;
        @(negedge clk);
        HALT = 1'b0;
        w0 = n_writes;
        carrega(32'hFFFF_FFF8, 16);
        @(negedge clk);
        inicio = 1'b0;
        espera_executa(80, 1'b0, "full");
        verifica("full_writes", 32'(n_writes - w0), 32'd16);
        verifica("full_wrap", 32'(seen_wrap), 32'd1);
        verifica("full_pending", 32'(exp_q.size()), 32'd0);

        // Reset has priority over HALT and over inicio.
        HALT = 1'b1; reset = 1'b1;
        @(negedge clk);
        verifica("prio_halt_estado", 32'(estado), 32'(OCIOSO));
        HALT = 1'b0;
        carrega(32'h900, 0);
        inicio = 1'b1; num_palavras = 5'd3;
        @(negedge clk);
        verifica("prio_inicio_estado", 32'(estado), 32'(OCIOSO));
        verifica("prio_inicio_ocupado", 32'(ocupado), 32'd0);
        reset = 1'b0; inicio = 1'b0;
        repeat (4) @(negedge clk);
        verifica("prio_idle", 32'(estado), 32'(OCIOSO));
        verifica("final_pending", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/controlador_carga_hd.md
CONTROLADOR_CARGA_HD -- requirements
Module: controlador_carga_hd

Interface
REQ-001 SHALL have parameter LARGURA_END, default 10: instruction-memory address width.
REQ-002 SHALL have parameter LATENCIA_HD, default 2: cycles from end_hd stable to HD_out valid, legal range 1..15.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports:
- clk  in  1  system clock (same clk as the processor)
- reset  in  1  synchronous, active-high
- inicio  in  1  start program load; sampled only in OCIOSO or PARADO
- end_base  in  32  first HD word address of the program
- num_palavras  in  LARGURA_END+1  words to load, 0..2^LARGURA_END
- HD_out  in  32  HD read data
- HALT  in  1  processor halt indication
- end_hd  out  32  HD read address
- end_mem_inst  out  LARGURA_END  instruction-memory write address
- dado_mem_inst  out  32  instruction-memory write data
- esc_mem_inst  out  1  instruction-memory write enable
- reset_proc  out  1  holds processor (gerencia_PC and register file) in reset
- ocupado  out  1  load in progress
- concluido  out  1  one-cycle pulse at load completion

Function
REQ-005 SHALL be a Moore FSM with states OCIOSO, ENDERECA, ESCREVE, EXECUTA and PARADO; all outputs SHALL be decoded from registered state and counters.
REQ-006 On OCIOSO/PARADO with inicio=1 and num_palavras>0, SHALL latch end_base and num_palavras, clear indice, and enter ENDERECA next cycle.
REQ-007 On OCIOSO/PARADO with inicio=1 and num_palavras=0, SHALL enter EXECUTA directly, with no writes and a concluido pulse.
REQ-008 In ENDERECA: end_hd = base + indice, modulo 2^32; SHALL stay exactly LATENCIA_HD cycles, then enter ESCREVE.
REQ-009 In ESCREVE, SHALL hold for exactly one cycle: esc_mem_inst=1, end_mem_inst=indice[LARGURA_END-1:0], dado_mem_inst=HD_out, end_hd unchanged.
REQ-010 Leaving ESCREVE: if indice = N-1, SHALL go to EXECUTA; else SHALL set indice+1 and go to ENDERECA.
REQ-011 Load time SHALL be exactly N*(LATENCIA_HD+1) cycles from the first ENDERECA cycle to the first EXECUTA cycle.
REQ-012 esc_mem_inst SHALL be 0 in every state except ESCREVE.
REQ-013 ocupado SHALL be 1 in ENDERECA and ESCREVE, else 0.
REQ-014 concluido SHALL be 1 only in the first EXECUTA cycle after a load.
REQ-015 reset_proc SHALL be 0 only in EXECUTA, else 1; the processor runs from PC reset value starting the first EXECUTA cycle.
REQ-016 In EXECUTA, HALT=1 SHALL move to PARADO next cycle.
REQ-017 HALT SHALL be ignored in all other states.
REQ-018 inicio SHALL be ignored in ENDERECA, ESCREVE and EXECUTA; no queuing.
REQ-019 Changes to end_base/num_palavras after acceptance SHALL have no effect on the running load.
REQ-020 N = 2^LARGURA_END SHALL load every address 0..2^LARGURA_END-1 exactly once with no address wrap.
REQ-021 HALT and inicio both high in EXECUTA SHALL give PARADO; inicio is not honoured.

Reset
REQ-022 reset=1 at a clock edge SHALL force: OCIOSO, indice=0, latency counter=0, esc_mem_inst=0, ocupado=0, concluido=0, reset_proc=1, end_hd=0, end_mem_inst=0, dado_mem_inst=0.
REQ-023 Reset in any state, mid-load included, SHALL abort with no further writes.
REQ-024 reset SHALL take priority over inicio and HALT in the same cycle.

Structure
REQ-025 A shared package SHALL hold the state encoding (3-bit enum) and the LARGURA_END/LATENCIA_HD defaults.
REQ-026 A sub-module temporizador_hd (4-bit load/decrement counter with terminal flag) SHALL implement the ENDERECA wait.
REQ-027 The top level SHALL insert reset_proc as OR with system reset into the processor's reset, with no other processor changes.

Verification
REQ-028 L=2, base=0x100, N=3, HD word = address ^ 0xA5A5: writes 0x0000A4A5@0, 0x0000A4A4@1, 0x0000A4A7@2 on cycles 3, 6, 9 after acceptance; concluido at cycle 10; reset_proc falls the same cycle.
REQ-029 N=0, inicio=1: next cycle EXECUTA with concluido=1, zero esc_mem_inst pulses.
REQ-030 Reset pulsed during second ENDERECA of an N=5 load: exactly one write seen, then OCIOSO with reset_proc=1; a new inicio restarts from indice 0.
REQ-031 inicio toggled every cycle during an N=4 load: exactly 4 writes, addresses 0..3.
REQ-032 HALT=1 in EXECUTA: PARADO next cycle with reset_proc=1; a later inicio with N=2 reloads and reruns.
REQ-033 LARGURA_END=4, N=16, base=0xFFFFFFF8: end_hd wraps 0xFFFFFFFF to 0x00000000; 16 writes cover addresses 0..15.
